alu_exec_unit: RTL

- Execution-stage ALU that consumes the 6-bit ALU operation code produced by the ALU-control decoder, together with the register/immediate operands.
- Logic ops and ADD complete in a single cycle. Shifts are iterative, one bit per cycle, to save area on the FPGA.
- A start/ready/done handshake lets the pipeline control stall EX while a shift is in progress.

---
 rtl/alu_exec_unit.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/alu_exec_unit.sv
// Execution-stage ALU: single-cycle logic/ADD ops, bit-serial shifts behind a
// start/ready/done handshake so pipeline control can stall EX during a shift.
module alu_exec_unit #(
    parameter int NB_DATA   = 32,
    parameter int NB_OP_ALU = 6,
    parameter int NB_SHAMT  = 5
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [NB_OP_ALU-1:0] alu_op,
    input  logic [NB_DATA-1:0]   operand_a,
    input  logic [NB_DATA-1:0]   operand_b,
    input  logic [NB_SHAMT-1:0]  shamt,
    output logic                 ready,
    output logic                 done,
    output logic [NB_DATA-1:0]   result,
    output logic                 zero,
    output logic                 overflow,
    output logic                 illegal_op
);

    localparam logic [NB_OP_ALU-1:0] OP_SLL = NB_OP_ALU'(6'b000000);
    localparam logic [NB_OP_ALU-1:0] OP_SRL = NB_OP_ALU'(6'b000010);
    localparam logic [NB_OP_ALU-1:0] OP_SRA = NB_OP_ALU'(6'b000011);
    localparam logic [NB_OP_ALU-1:0] OP_ADD = NB_OP_ALU'(6'b100000);
    localparam logic [NB_OP_ALU-1:0] OP_AND = NB_OP_ALU'(6'b100100);
    localparam logic [NB_OP_ALU-1:0] OP_OR  = NB_OP_ALU'(6'b100101);
    localparam logic [NB_OP_ALU-1:0] OP_XOR = NB_OP_ALU'(6'b100110);
    localparam logic [NB_OP_ALU-1:0] OP_NOR = NB_OP_ALU'(6'b100111);

    localparam logic [NB_SHAMT-1:0] CNT_ZERO = NB_SHAMT'(0);
    localparam logic [NB_SHAMT-1:0] CNT_ONE  = NB_SHAMT'(1);
    localparam logic [NB_DATA-1:0]  DATA_ZERO = NB_DATA'(0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t               state_r;
    logic [NB_OP_ALU-1:0] op_r;
    logic [NB_DATA-1:0]   shreg_r;
    logic [NB_SHAMT-1:0]  cnt_r;
    logic                 ready_r;
    logic                 done_r;
    logic [NB_DATA-1:0]   result_r;
    logic                 zero_r;
    logic                 overflow_r;
    logic                 illegal_r;

    logic [NB_DATA-1:0]   sum_s;
    logic [NB_DATA-1:0]   alu_res_s;
    logic                 alu_ovf_s;
    logic                 alu_ill_s;
    logic                 is_shift_s;
    logic [NB_DATA-1:0]   shift_next_s;

    // One-bit shift step; the op held in op_r selects direction and fill bit.
    function automatic logic [NB_DATA-1:0] shift_one(
        input logic [NB_DATA-1:0]   value,
        input logic [NB_OP_ALU-1:0] op
    );
        logic [NB_DATA-1:0] res;
        case (op)
            OP_SLL:  res = {value[NB_DATA-2:0], 1'b0};
            OP_SRL:  res = {1'b0, value[NB_DATA-1:1]};
            OP_SRA:  res = {value[NB_DATA-1], value[NB_DATA-1:1]};
            default: res = value;
        endcase
        return res;
    endfunction

    // Single-cycle datapath on the live inputs, used at the accept edge.
    always_comb begin
        sum_s      = operand_a + operand_b;
        alu_res_s  = DATA_ZERO;
        alu_ovf_s  = 1'b0;
        alu_ill_s  = 1'b0;
        is_shift_s = 1'b0;
        case (alu_op)
            OP_ADD: begin
                alu_res_s = sum_s;
                alu_ovf_s = (operand_a[NB_DATA-1] == operand_b[NB_DATA-1]) &&
                            (sum_s[NB_DATA-1] != operand_a[NB_DATA-1]);
            end
            OP_AND: alu_res_s = operand_a & operand_b;
            OP_OR:  alu_res_s = operand_a | operand_b;
            OP_XOR: alu_res_s = operand_a ^ operand_b;
            OP_NOR: alu_res_s = ~(operand_a | operand_b);
            OP_SLL, OP_SRL, OP_SRA: begin
                // shamt=0 completes immediately with the unshifted source
                alu_res_s  = operand_b;
                is_shift_s = 1'b1;
            end
            default: alu_ill_s = 1'b1;
        endcase
    end

    // Next value of the iterative shift register.
    always_comb begin
        shift_next_s = shift_one(shreg_r, op_r);
    end

    // Control FSM with registered handshake, result and flags.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r    <= ST_IDLE;
            op_r       <= NB_OP_ALU'(0);
            shreg_r    <= DATA_ZERO;
            cnt_r      <= CNT_ZERO;
            ready_r    <= 1'b1;
            done_r     <= 1'b0;
            result_r   <= DATA_ZERO;
            zero_r     <= 1'b1;
            overflow_r <= 1'b0;
            illegal_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        op_r    <= alu_op;
                        ready_r <= 1'b0;
                        if (is_shift_s && (shamt != CNT_ZERO)) begin
                            shreg_r <= operand_b;
                            cnt_r   <= shamt;
                            state_r <= ST_SHIFT;
                        end else begin
                            result_r   <= alu_res_s;
                            zero_r     <= (alu_res_s == DATA_ZERO);
                            overflow_r <= alu_ovf_s;
                            illegal_r  <= alu_ill_s;
                            done_r     <= 1'b1;
                            state_r    <= ST_DONE;
                        end
                    end else begin
                        ready_r <= 1'b1;
                        done_r  <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    shreg_r <= shift_next_s;
                    if (cnt_r == CNT_ONE) begin
                        // final step: publish the result without a wrap of the counter
                        cnt_r      <= CNT_ZERO;
                        result_r   <= shift_next_s;
                        zero_r     <= (shift_next_s == DATA_ZERO);
                        overflow_r <= 1'b0;
                        illegal_r  <= 1'b0;
                        done_r     <= 1'b1;
                        state_r    <= ST_DONE;
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                ST_DONE: begin
                    done_r  <= 1'b0;
                    ready_r <= 1'b1;
                    state_r <= ST_IDLE;
                end
                default: begin
                    done_r  <= 1'b0;
                    ready_r <= 1'b1;
                    cnt_r   <= CNT_ZERO;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign ready      = ready_r;
    assign done       = done_r;
    assign result     = result_r;
    assign zero       = zero_r;
    assign overflow   = overflow_r;
    assign illegal_op = illegal_r;

endmodule
